// File: rtl/dac_spi_pkg.sv
// Shared definitions for the DAC SPI responder.
// Contents: default frame length, command bit positions, the decoded
// command layout and the receive FSM state encoding.
package dac_spi_pkg;

  localparam int FRAME_BITS_DEF = 16;

  localparam int AB_BIT   = 15;
  localparam int BUF_BIT  = 14;
  localparam int GA_BIT   = 13;
  localparam int SHDN_BIT = 12;

  // Write frame as it sits in the shift register, MSB first on the wire.
  typedef struct packed {
    logic        ab;      // 0 = channel A, 1 = channel B
    logic        buf_;
    logic        ga_n;
    logic        shdn_n;
    logic [11:0] data;
  } dac_cmd_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } rx_state_t;

endpackage

// File: rtl/spi_pin_sync.sv
// Synchronizer plus edge detector for one asynchronous SPI pin.
// Ports:
//   clk, rst  - system clock, async active-high reset
//   pin       - raw asynchronous input
//   level     - synchronized level (last sync stage)
//   rise/fall - single-cycle edge flags from last stage vs history flop
// All flops reset to RST_VAL so no edge is reported at reset release.
module spi_pin_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      hist_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  =  level & ~hist_q;
  assign fall  = ~level &  hist_q;

endmodule

// File: rtl/dac_spi_receiver.sv
// DAC side of the dual-channel 12-bit SPI link (MCP4922-style).
// Decodes 16-bit write frames into per-channel input registers and
// copies them to the output registers while LDAC is low.
// Ports:
//   CLK100, RESET         - system clock, async active-high reset
//   CS, SCK, SDI, LDAC    - asynchronous SPI / latch pins
//   DAC_A, DAC_B          - channel output registers
//   CFG_A, CFG_B          - {BUF, GA_n, SHDN_n} of last committed frame
//   FRAME_DONE, FRAME_ERR - single-cycle frame status pulses
//   LDAC_XFER             - high in every cycle inputs copy to outputs
module dac_spi_receiver
  import dac_spi_pkg::*;
#(
  parameter int FRAME_BITS  = FRAME_BITS_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic        CLK100,
  input  logic        RESET,
  input  logic        CS,
  input  logic        SCK,
  input  logic        SDI,
  input  logic        LDAC,
  output logic [11:0] DAC_A,
  output logic [11:0] DAC_B,
  output logic [2:0]  CFG_A,
  output logic [2:0]  CFG_B,
  output logic        FRAME_DONE,
  output logic        FRAME_ERR,
  output logic        LDAC_XFER
);

  // Pin lanes: 0 = CS, 1 = SCK, 2 = SDI, 3 = LDAC. CS and LDAC idle high.
  localparam int         NUM_PINS = 4;
  localparam logic [3:0] PIN_RST  = 4'b1001;

  logic [NUM_PINS-1:0] pin_raw, pin_lvl, pin_rise, pin_fall;

  assign pin_raw = {LDAC, SDI, SCK, CS};

  for (genvar p = 0; p < NUM_PINS; p++) begin : g_sync
    spi_pin_sync #(
      .SYNC_STAGES (SYNC_STAGES),
      .RST_VAL     (PIN_RST[p])
    ) u_sync (
      .clk   (CLK100),
      .rst   (RESET),
      .pin   (pin_raw[p]),
      .level (pin_lvl[p]),
      .rise  (pin_rise[p]),
      .fall  (pin_fall[p])
    );
  end

  logic cs_lvl, cs_rise, cs_fall, sck_rise, sdi_lvl, ldac_lvl;
  assign cs_lvl   = pin_lvl[0];
  assign cs_rise  = pin_rise[0];
  assign cs_fall  = pin_fall[0];
  assign sck_rise = pin_rise[1];
  assign sdi_lvl  = pin_lvl[2];
  assign ldac_lvl = pin_lvl[3];

  logic unused_edges;
  assign unused_edges = ^{pin_lvl[1], pin_fall[3:1], pin_rise[3:2]};

  localparam logic [4:0] CNT_FULL  = 5'd31;
  localparam logic [4:0] CNT_FRAME = 5'(FRAME_BITS);

  rx_state_t   state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] sh_q, sh_d;
  logic        err_q, err_d;
  logic        commit;
  logic [11:0] in_a_q, in_b_q;
  dac_cmd_t    cmd;

  assign cmd = dac_cmd_t'(sh_q);

  always_ff @(posedge CLK100 or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      err_q   <= err_d;
    end
  end

  // SHIFT checks CS rise before SCK rise, so a coincident SCK edge is
  // dropped and the frame is judged on the count accumulated so far.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    err_d   = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (cs_fall) state_d = SHIFT;
      end
      SHIFT: begin
        if (cs_rise) begin
          if (cnt_q == CNT_FRAME) begin
            state_d = COMMIT;
          end else begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end else if (sck_rise && !cs_lvl) begin
          sh_d  = {sh_q[14:0], sdi_lvl};
          cnt_d = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + 5'd1;
        end
      end
      COMMIT: begin
        commit = 1'b1;
        // A new frame may start right away; keep its CS fall.
        if (cs_fall) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Channel registers. LDAC copies the pre-commit input values since both
  // are non-blocking updates of the same edge.
  always_ff @(posedge CLK100 or posedge RESET) begin
    if (RESET) begin
      in_a_q <= '0;
      in_b_q <= '0;
      CFG_A  <= '0;
      CFG_B  <= '0;
      DAC_A  <= '0;
      DAC_B  <= '0;
    end else begin
      if (commit) begin
        if (cmd.ab) begin
          in_b_q <= cmd.data;
          CFG_B  <= {cmd.buf_, cmd.ga_n, cmd.shdn_n};
        end else begin
          in_a_q <= cmd.data;
          CFG_A  <= {cmd.buf_, cmd.ga_n, cmd.shdn_n};
        end
      end
      if (!ldac_lvl) begin
        DAC_A <= in_a_q;
        DAC_B <= in_b_q;
      end
    end
  end

  assign FRAME_DONE = commit;
  assign FRAME_ERR  = err_q;
  assign LDAC_XFER  = ~ldac_lvl;

endmodule

// File: tb/tb_dac_spi_receiver.sv
// Directed self-checking bench for dac_spi_receiver.
module tb_dac_spi_receiver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs = 1'b1, sck = 1'b0, sdi = 1'b0, ldac = 1'b1;
  logic [11:0] dac_a, dac_b;
  logic [2:0]  cfg_a, cfg_b;
  logic        frame_done, frame_err, ldac_xfer;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int xfer_cnt = 0;

  always #5 clk = ~clk;

  dac_spi_receiver #(.FRAME_BITS(16), .SYNC_STAGES(2)) dut (
    .CLK100     (clk),
    .RESET      (rst),
    .CS         (cs),
    .SCK        (sck),
    .SDI        (sdi),
    .LDAC       (ldac),
    .DAC_A      (dac_a),
    .DAC_B      (dac_b),
    .CFG_A      (cfg_a),
    .CFG_B      (cfg_b),
    .FRAME_DONE (frame_done),
    .FRAME_ERR  (frame_err),
    .LDAC_XFER  (ldac_xfer)
  );

  // Pulse monitors, sampled away from the active edge.
  always @(negedge clk) begin
    if (frame_done) done_cnt++;
    if (frame_err)  err_cnt++;
    if (ldac_xfer)  xfer_cnt++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [31:0] word, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      sdi = word[i];
      wait_clk(3);
      sck = 1'b1;
      wait_clk(3);
      sck = 1'b0;
    end
  endtask

  task automatic spi_frame(input logic [31:0] word, input int nbits);
    cs = 1'b0;
    wait_clk(4);
    spi_bits(word, nbits);
    wait_clk(3);
    cs = 1'b1;
    wait_clk(6);
  endtask

  task automatic ldac_pulse(input int n);
    ldac = 1'b0;
    wait_clk(n);
    ldac = 1'b1;
    wait_clk(5);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(3);
    n_checks++;
    if ({dac_a, dac_b} !== 24'h0) begin
      n_fail++; $display("FAIL reset_dac: got %h/%h want 000/000", dac_a, dac_b);
    end
    n_checks++;
    if ({cfg_a, cfg_b} !== 6'b0) begin
      n_fail++; $display("FAIL reset_cfg: got %b/%b want 000/000", cfg_a, cfg_b);
    end
    n_checks++;
    if ({frame_done, frame_err, ldac_xfer} !== 3'b000 || done_cnt + err_cnt + xfer_cnt != 0) begin
      n_fail++; $display("FAIL reset_pulses: got %b counts %0d/%0d/%0d want 000 and zero counts",
                         {frame_done, frame_err, ldac_xfer}, done_cnt, err_cnt, xfer_cnt);
    end
  endtask

  task automatic test_frame_a;
    int d0, x0;
    d0 = done_cnt;
    spi_frame(32'h3ABC, 16);
    n_checks++;
    if (done_cnt - d0 != 1) begin
      n_fail++; $display("FAIL a_done_pulses: got %0d want 1", done_cnt - d0);
    end
    n_checks++;
    if (cfg_a !== 3'b011 || dac_a !== 12'h000) begin
      n_fail++; $display("FAIL a_pre_ldac: got cfg %b dac %h want 011/000", cfg_a, dac_a);
    end
    x0 = xfer_cnt;
    ldac_pulse(4);
    n_checks++;
    if (xfer_cnt - x0 != 4) begin
      n_fail++; $display("FAIL a_xfer_cycles: got %0d want 4", xfer_cnt - x0);
    end
    n_checks++;
    if (dac_a !== 12'hABC || dac_b !== 12'h000) begin
      n_fail++; $display("FAIL a_post_ldac: got %h/%h want abc/000", dac_a, dac_b);
    end
  endtask

  task automatic test_frame_b;
    spi_frame(32'hB081, 16);
    n_checks++;
    if (cfg_b !== 3'b011 || dac_b !== 12'h000 || dac_a !== 12'hABC) begin
      n_fail++; $display("FAIL b_pre_ldac: got cfg_b %b dac %h/%h want 011 abc/000", cfg_b, dac_a, dac_b);
    end
    ldac_pulse(2);
    n_checks++;
    if (dac_b !== 12'h081 || dac_a !== 12'hABC) begin
      n_fail++; $display("FAIL b_post_ldac: got %h/%h want abc/081", dac_a, dac_b);
    end
  endtask

  task automatic test_bad_length;
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    spi_frame(32'h7FFF, 15);
    spi_frame(32'h1FFFF, 17);
    n_checks++;
    if (err_cnt - e0 != 2 || done_cnt != d0) begin
      n_fail++; $display("FAIL bad_len_pulses: got err %0d done %0d want 2/0", err_cnt - e0, done_cnt - d0);
    end
    n_checks++;
    if (cfg_a !== 3'b011 || cfg_b !== 3'b011) begin
      n_fail++; $display("FAIL bad_len_cfg: got %b/%b want 011/011", cfg_a, cfg_b);
    end
    ldac_pulse(2);
    n_checks++;
    if (dac_a !== 12'hABC || dac_b !== 12'h081) begin
      n_fail++; $display("FAIL bad_len_inputs: got %h/%h want abc/081", dac_a, dac_b);
    end
  endtask

  task automatic test_shutdown;
    spi_frame(32'h2123, 16);
    n_checks++;
    if (cfg_a !== 3'b010 || dac_a !== 12'hABC) begin
      n_fail++; $display("FAIL shdn_cfg: got cfg %b dac %h want 010/abc", cfg_a, dac_a);
    end
    ldac_pulse(2);
    n_checks++;
    if (dac_a !== 12'h123) begin
      n_fail++; $display("FAIL shdn_dac: got %h want 123", dac_a);
    end
  endtask

  task automatic test_reset_mid_frame;
    int e0;
    e0 = err_cnt;
    cs = 1'b0;
    wait_clk(4);
    spi_bits(32'h00A5, 8);
    rst = 1'b1;
    cs  = 1'b1;
    wait_clk(4);
    rst = 1'b0;
    wait_clk(4);
    n_checks++;
    if ({dac_a, dac_b, cfg_a, cfg_b} !== 30'h0) begin
      n_fail++; $display("FAIL midrst_clear: got %h/%h %b/%b want all zero", dac_a, dac_b, cfg_a, cfg_b);
    end
    spi_frame(32'h3005, 16);
    n_checks++;
    if (cfg_a !== 3'b011 || dac_a !== 12'h000 || err_cnt != e0) begin
      n_fail++; $display("FAIL midrst_frame: got cfg %b dac %h errs %0d want 011/000/0", cfg_a, dac_a, err_cnt - e0);
    end
    ldac_pulse(2);
    n_checks++;
    if (dac_a !== 12'h005 || dac_b !== 12'h000) begin
      n_fail++; $display("FAIL midrst_ldac: got %h/%h want 005/000", dac_a, dac_b);
    end
  endtask

  // LDAC held low across a commit: outputs follow one cycle after input write.
  task automatic test_ldac_held;
    ldac = 1'b0;
    wait_clk(4);
    spi_frame(32'h3055, 16);
    n_checks++;
    if (dac_a !== 12'h055 || ldac_xfer !== 1'b1) begin
      n_fail++; $display("FAIL ldac_held: got dac %h xfer %b want 055/1", dac_a, ldac_xfer);
    end
    ldac = 1'b1;
    wait_clk(5);
  endtask

  // Controller-style loopback: A = 157, B = 2073, then LDAC, repeated.
  task automatic test_back_to_back;
    for (int it = 0; it < 100; it++) begin
      spi_frame(32'h3000 | 32'd157, 16);
      spi_frame(32'hB000 | 32'd2073, 16);
      ldac_pulse(2);
      n_checks++;
      if (dac_a !== 12'd157 || dac_b !== 12'd2073) begin
        n_fail++; $display("FAIL loopback_%0d: got %0d/%0d want 157/2073", it, dac_a, dac_b);
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame_a();
    test_frame_b();
    test_bad_length();
    test_shutdown();
    test_reset_mid_frame();
    test_ldac_held();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dac_spi_receiver.md
# dac_spi_receiver

Synthesizable SPI responder for the dual-channel 12-bit DAC link (CS, SCK, SDI, LDAC), i.e. the DAC side of the frames our DAC controller transmits. It decodes 16-bit write frames into per-channel input registers and transfers them to output registers on LDAC, as an MCP4922-style DAC does. It is used for on-board loopback (GPIO in to LED/RGB readout) and as the checking model in DAC controller benches.

## Interface
- FRAME_BITS, 16: SCK rising edges per valid frame.
- SYNC_STAGES, 2: synchronizer flops per SPI pin (≥2).
- CLK100 in 1: 100 MHz system clock; all logic on its rising edge.
- RESET in 1: asynchronous, active-high reset.
- CS in 1: chip select, active low, asynchronous to CLK100.
- SCK in 1: SPI clock, asynchronous.
- SDI in 1: serial data, MSB first, valid on SCK rise.
- LDAC in 1: latch strobe, active low, level-sensitive.
- DAC_A, DAC_B out 12 each: channel output registers.
- CFG_A, CFG_B out 3 each: {BUF, GA_n, SHDN_n} from the last committed frame per channel.
- FRAME_DONE out 1: one-cycle pulse when a valid frame commits.
- FRAME_ERR out 1: one-cycle pulse when a frame ends with a bit count ≠ FRAME_BITS.
- LDAC_XFER out 1: high in every cycle in which input registers are copied to outputs.

## Operation
- Each pin passes through SYNC_STAGES flops, then one history flop. Edges are detected from the last sync stage and that history flop.
- Frame format, bit15→bit0: A/B̄ select (0 = A, 1 = B), BUF, GA_n, SHDN_n, D[11:0].
- FSM IDLE: CS_s high, bit counter held at 0. CS falling → SHIFT, counter cleared.
- FSM SHIFT: each SCK rise shifts SDI_s into a 16-bit register from the LSB side and increments a 5-bit counter that saturates at 31.
  - CS rising with count == FRAME_BITS → COMMIT.
  - CS rising with any other count → IDLE, pulse FRAME_ERR, no register change.
- FSM COMMIT (one cycle): write D into IN_A or IN_B and the 3 config bits into CFG_A or CFG_B; pulse FRAME_DONE; go to IDLE.
- An SCK rise seen while CS_s is high is ignored.
- If SCK rise and CS rise are detected in the same cycle, the SCK edge is dropped and the frame is judged on the prior count.
- If CS falls again in COMMIT, that falling edge is honoured: the next state is SHIFT with the counter cleared.
- LDAC_s low in a cycle: DAC_A ← IN_A and DAC_B ← IN_B, LDAC_XFER = 1.
- The transfer reads input registers as they were before any same-cycle COMMIT write. The new value propagates on the next cycle if LDAC is still low.
- CFG outputs update at COMMIT, not on LDAC.
- Reset values:
  - DAC_A, DAC_B, IN_A, IN_B = 12'h000.
  - CFG_A, CFG_B = 3'b000.
  - All pulses 0, FSM = IDLE, counter 0.
  - Sync and history flops = CS 1, LDAC 1, SCK 0, SDI 0, so no edge is seen at reset release.
- RESET mid-frame discards the partial frame. Frame reception resumes only after a fresh CS fall.

## Timing
- A pin edge first sampled at CLK100 edge k is acted on at edge k+SYNC_STAGES. The registered result is visible after that edge.
- CS rise to DAC input register: 1 further cycle (COMMIT). FRAME_DONE is high that same cycle.
- LDAC low to DAC_A/DAC_B update: SYNC_STAGES cycles.
- SCK high and low times must each be ≥ SYNC_STAGES+1 CLK100 periods; faster SCK is unsupported.
- CS high time must be ≥ 2 cycles.
- SDI must be stable across the SCK rise for one synchronizer sample; the same-length sync paths keep SDI aligned with SCK.

## Structure
- Package dac_spi_pkg holds:
  - FRAME_BITS default and bit positions AB_BIT = 15, BUF_BIT = 14, GA_BIT = 13, SHDN_BIT = 12.
  - typedef dac_cmd_t, a packed struct {ab, buf_, ga_n, shdn_n, logic [11:0] data}.
  - typedef rx_state_t, an enum {IDLE, SHIFT, COMMIT}.
- One sub-module, spi_pin_sync (parameter SYNC_STAGES, reset value; outputs level, rise, fall), instantiated once per pin.
- The shift register, FSM and channel registers live in dac_spi_receiver.

## Test plan
- Reset then frame 16'h3ABC followed by a 4-cycle LDAC low → DAC_A = 12'hABC, CFG_A = 3'b011, DAC_B = 0, FRAME_DONE pulses once, LDAC_XFER high for 4 cycles.
- Frame 16'hB081 with LDAC held high → CFG_B = 3'b011 immediately, DAC_B stays 0; a later LDAC pulse sets DAC_B = 12'h081.
- 15-bit frame, then 17-bit frame → FRAME_ERR pulses twice, FRAME_DONE never pulses, IN_A, IN_B and CFG unchanged.
- Frame 16'h2123 (SHDN_n = 0) → CFG_A = 3'b010; LDAC then gives DAC_A = 12'h123.
- RESET asserted after 8 SCK edges of a frame, released, then a full frame 16'h3005 → outputs are 0 until the new frame commits; no error pulse appears for the aborted frame.
- Loopback with the DAC controller sending A = 157, B = 2073 → DAC_A = 157 and DAC_B = 2073 after its LDAC, sustained over 100 repeated updates.
